// File: rtl/alarm_set_controller.sv
// -----------------------------------------------------------------------------
// alarm_set_controller
//   Push-button sequencer for the clock/alarm datapath. Each raw button passes
//   through a 2-FF synchroniser, a debouncer and a rising-edge detector. Mode
//   presses walk RUN -> SET_ALARM -> ARMED -> RUN, or acknowledge a sounding
//   alarm instead. In SET_ALARM, minute/hour presses produce one-cycle
//   increment strobes, with hold-to-repeat while the button stays down.
//
// Ports
//   CLK       in   system clock, all state on posedge
//   CLR_n     in   asynchronous active-low reset
//   btnMode   in   raw mode button (active-high, asynchronous)
//   btnMin    in   raw minute button (active-high, asynchronous)
//   btnHour   in   raw hour button (active-high, asynchronous)
//   ALARM     in   alarm-sounding indication from the datapath
//   Mode      out  00 RUN, 01 SET_ALARM, 10 ARMED
//   minUP     out  one-cycle alarm-minute increment strobe
//   hourUP    out  one-cycle alarm-hour increment strobe
//   alarmAck  out  one-cycle alarm acknowledge strobe
// -----------------------------------------------------------------------------
module alarm_set_controller #(
  parameter int unsigned DEBOUNCE_CYCLES = 1_000_000,
  parameter int unsigned HOLD_CYCLES     = 50_000_000,
  parameter int unsigned REPEAT_CYCLES   = 20_000_000
) (
  input  logic       CLK,
  input  logic       CLR_n,
  input  logic       btnMode,
  input  logic       btnMin,
  input  logic       btnHour,
  input  logic       ALARM,
  output logic [1:0] Mode,
  output logic       minUP,
  output logic       hourUP,
  output logic       alarmAck
);

  localparam logic [1:0] RUN       = 2'b00;
  localparam logic [1:0] SET_ALARM = 2'b01;
  localparam logic [1:0] ARMED     = 2'b10;

  // Debounce counter only ever needs to reach DEBOUNCE_CYCLES-1.
  localparam int unsigned     DB_W    = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);

  localparam int unsigned     RP_MAX      = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
  localparam int unsigned     RP_W        = $clog2(RP_MAX + 1);
  localparam logic [RP_W-1:0] HOLD_LAST   = RP_W'(HOLD_CYCLES);
  localparam logic [RP_W-1:0] REPEAT_LAST = RP_W'(REPEAT_CYCLES);
  localparam logic [RP_W-1:0] RP_TOP      = RP_W'(RP_MAX);
  localparam logic [RP_W-1:0] RP_ONE      = RP_W'(1);

  // Bit 0 = mode, bit 1 = minute, bit 2 = hour.
  logic [2:0] raw;
  logic [2:0] held;
  logic [2:0] rise;

  assign raw = {btnHour, btnMin, btnMode};

  // ---------------------------------------------------------------------------
  // Per-button synchroniser, debouncer and rising-edge detector
  // ---------------------------------------------------------------------------
  for (genvar g = 0; g < 3; g++) begin : g_btn
    logic            sync1_q, sync2_q;
    logic            stable_q, stable_d;
    logic            stable_dly_q;
    logic [DB_W-1:0] db_cnt_q, db_cnt_d;

    // The counter only runs while the synchronised level disagrees with the
    // accepted level; any agreement restarts the qualification window.
    always_comb begin
      db_cnt_d = '0;
      stable_d = stable_q;
      if (sync2_q != stable_q) begin
        if (db_cnt_q == DB_LAST) begin
          stable_d = ~stable_q;
        end else begin
          db_cnt_d = db_cnt_q + 1'b1;
        end
      end
    end

    always_ff @(posedge CLK or negedge CLR_n) begin
      if (!CLR_n) begin
        sync1_q      <= 1'b0;
        sync2_q      <= 1'b0;
        stable_q     <= 1'b0;
        stable_dly_q <= 1'b0;
        db_cnt_q     <= '0;
      end else begin
        sync1_q      <= raw[g];
        sync2_q      <= sync1_q;
        stable_q     <= stable_d;
        stable_dly_q <= stable_q;
        db_cnt_q     <= db_cnt_d;
      end
    end

    assign held[g] = stable_q;
    assign rise[g] = stable_q & ~stable_dly_q;
  end

  // ---------------------------------------------------------------------------
  // Mode FSM: state register / next-state / outputs
  // ---------------------------------------------------------------------------
  logic [1:0] mode_q, mode_d;
  logic       mode_ev;
  logic       in_set;

  assign mode_ev = rise[0];
  assign in_set  = (mode_q == SET_ALARM);

  always_ff @(posedge CLK or negedge CLR_n) begin
    if (!CLR_n) begin
      mode_q <= RUN;
    end else begin
      mode_q <= mode_d;
    end
  end

  // A mode press while the alarm sounds is an acknowledge, not a mode step.
  always_comb begin
    mode_d = mode_q;
    unique case (mode_q)
      RUN:       if (mode_ev && !ALARM) mode_d = SET_ALARM;
      SET_ALARM: if (mode_ev && !ALARM) mode_d = ARMED;
      ARMED:     if (mode_ev && !ALARM) mode_d = RUN;
      default:   mode_d = RUN;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Minute / hour hold-to-repeat strobes (index 0 = minute, 1 = hour)
  // ---------------------------------------------------------------------------
  // cnt_q == 0 means idle; it is armed to 1 by a press in SET_ALARM so a
  // button already held when entering SET_ALARM never starts repeating.
  logic [1:0] strobe_d;

  for (genvar k = 0; k < 2; k++) begin : g_rpt
    logic [RP_W-1:0] cnt_q, cnt_d;
    logic            rep_q, rep_d;
    logic            fire;

    always_comb begin
      cnt_d = '0;
      rep_d = 1'b0;
      fire  = 1'b0;
      if (in_set) begin
        if (rise[k+1]) begin
          fire  = 1'b1;
          cnt_d = RP_ONE;
        end else if (held[k+1] && (cnt_q != '0)) begin
          rep_d = rep_q;
          if (cnt_q == (rep_q ? REPEAT_LAST : HOLD_LAST)) begin
            fire  = 1'b1;
            cnt_d = RP_ONE;
            rep_d = 1'b1;
          end else if (cnt_q != RP_TOP) begin
            cnt_d = cnt_q + 1'b1;
          end else begin
            cnt_d = cnt_q;
          end
        end
      end
    end

    always_ff @(posedge CLK or negedge CLR_n) begin
      if (!CLR_n) begin
        cnt_q <= '0;
        rep_q <= 1'b0;
      end else begin
        cnt_q <= cnt_d;
        rep_q <= rep_d;
      end
    end

    assign strobe_d[k] = fire;
  end

  // ---------------------------------------------------------------------------
  // Registered outputs (strobes see the pre-transition mode)
  // ---------------------------------------------------------------------------
  logic min_up_q, hour_up_q, ack_q;
  logic ack_d;

  always_comb begin
    ack_d = mode_ev & ALARM;
  end

  always_ff @(posedge CLK or negedge CLR_n) begin
    if (!CLR_n) begin
      min_up_q  <= 1'b0;
      hour_up_q <= 1'b0;
      ack_q     <= 1'b0;
    end else begin
      min_up_q  <= strobe_d[0];
      hour_up_q <= strobe_d[1];
      ack_q     <= ack_d;
    end
  end

  assign Mode     = mode_q;
  assign minUP    = min_up_q;
  assign hourUP   = hour_up_q;
  assign alarmAck = ack_q;

endmodule

// File: tb/tb_alarm_set_controller.sv
module tb_alarm_set_controller;

  localparam int unsigned DB  = 4;
  localparam int unsigned HLD = 20;
  localparam int unsigned RPT = 8;

  localparam int K_MIN  = 0;
  localparam int K_HOUR = 1;
  localparam int K_ACK  = 2;
  localparam int K_MODE = 3;

  logic       CLK = 1'b0;
  logic       CLR_n = 1'b0;
  logic       btnMode = 1'b0;
  logic       btnMin = 1'b0;
  logic       btnHour = 1'b0;
  logic       ALARM = 1'b0;
  logic [1:0] Mode;
  logic       minUP;
  logic       hourUP;
  logic       alarmAck;

  alarm_set_controller #(
    .DEBOUNCE_CYCLES(DB),
    .HOLD_CYCLES    (HLD),
    .REPEAT_CYCLES  (RPT)
  ) dut (
    .CLK     (CLK),
    .CLR_n   (CLR_n),
    .btnMode (btnMode),
    .btnMin  (btnMin),
    .btnHour (btnHour),
    .ALARM   (ALARM),
    .Mode    (Mode),
    .minUP   (minUP),
    .hourUP  (hourUP),
    .alarmAck(alarmAck)
  );

  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  typedef struct {
    int kind;
    int val;
    int cyc;
  } ev_t;

  ev_t exp_q[$];
  int  n_pass  = 0;
  int  n_total = 0;

  task automatic check(input string name, input int act, input int req);
    n_total++;
    if (act == req) n_pass++;
    else $display("FAIL %s: got %0d, required %0d", name, act, req);
  endtask

  task automatic expect_ev(input int kind, input int val, input int c);
    ev_t e;
    e.kind = kind;
    e.val  = val;
    e.cyc  = c;
    exp_q.push_back(e);
  endtask

  task automatic observe(input int kind, input int val);
    ev_t e;
    n_total++;
    if (exp_q.size() == 0) begin
      $display("FAIL unexpected_output: got kind %0d val %0d at cycle %0d, required none", kind, val, cyc);
    end else begin
      e = exp_q.pop_front();
      if (e.kind == kind && e.val == val && e.cyc == cyc) n_pass++;
      else $display("FAIL sb_event: got kind %0d val %0d cycle %0d, required kind %0d val %0d cycle %0d",
                    kind, val, cyc, e.kind, e.val, e.cyc);
    end
  endtask

  // Monitor: every strobe and every Mode change is an output event.
  logic [1:0] prev_mode = 2'b00;
  always @(negedge CLK) begin
    if (!CLR_n) begin
      prev_mode = 2'b00;
    end else begin
      if (minUP)    observe(K_MIN, 1);
      if (hourUP)   observe(K_HOUR, 1);
      if (alarmAck) observe(K_ACK, 1);
      if (Mode != prev_mode) begin
        observe(K_MODE, int'(Mode));
        prev_mode = Mode;
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  initial begin
    int c;
    int e;

    // Reset state
    step(3);
    check("reset_mode", int'(Mode), 0);
    check("reset_minUP", int'(minUP), 0);
    check("reset_hourUP", int'(hourUP), 0);
    check("reset_alarmAck", int'(alarmAck), 0);
    CLR_n = 1'b1;
    step(3);

    // Mode press held: single advance to SET_ALARM at t+3+DB
    c = cyc;
    expect_ev(K_MODE, 1, c + 7);
    btnMode = 1'b1;
    step(20);
    check("mode_held_once", int'(Mode), 1);
    btnMode = 1'b0;
    step(12);

    // 3-cycle glitch rejected, then a real press gives one strobe
    btnMin = 1'b1;
    step(3);
    btnMin = 1'b0;
    step(12);
    c = cyc;
    expect_ev(K_MIN, 1, c + 7);
    btnMin = 1'b1;
    step(10);
    btnMin = 1'b0;
    step(12);

    // Hour held: strobe at +0, +20, then every 8
    c = cyc;
    e = c + 7;
    expect_ev(K_HOUR, 1, e);
    expect_ev(K_HOUR, 1, e + 20);
    expect_ev(K_HOUR, 1, e + 28);
    expect_ev(K_HOUR, 1, e + 36);
    expect_ev(K_HOUR, 1, e + 44);
    expect_ev(K_HOUR, 1, e + 52);
    btnHour = 1'b1;
    step(58);
    btnHour = 1'b0;
    step(30);

    // Mode and minute pressed together: strobe uses SET_ALARM, Mode -> ARMED
    c = cyc;
    expect_ev(K_MIN, 1, c + 7);
    expect_ev(K_MODE, 2, c + 7);
    btnMode = 1'b1;
    btnMin  = 1'b1;
    step(10);
    btnMode = 1'b0;
    btnMin  = 1'b0;
    step(12);

    // ARMED: min/hour ignored
    btnMin  = 1'b1;
    btnHour = 1'b1;
    step(30);
    btnMin  = 1'b0;
    btnHour = 1'b0;
    step(12);

    // ARMED -> RUN, then min/hour ignored in RUN
    c = cyc;
    expect_ev(K_MODE, 0, c + 7);
    btnMode = 1'b1;
    step(10);
    btnMode = 1'b0;
    step(12);
    btnHour = 1'b1;
    btnMin  = 1'b1;
    step(30);
    btnHour = 1'b0;
    btnMin  = 1'b0;
    step(12);

    // Alarm sounding: mode press acknowledges, Mode stays RUN
    ALARM = 1'b1;
    c = cyc;
    expect_ev(K_ACK, 1, c + 7);
    btnMode = 1'b1;
    step(10);
    btnMode = 1'b0;
    step(12);
    check("ack_mode_unchanged", int'(Mode), 0);
    ALARM = 1'b0;

    // Alarm quiet: mode advances to SET_ALARM
    c = cyc;
    expect_ev(K_MODE, 1, c + 7);
    btnMode = 1'b1;
    step(10);
    btnMode = 1'b0;
    step(12);

    // Both held in SET_ALARM; reset lands on the +20 repeat strobe
    c = cyc;
    e = c + 7;
    expect_ev(K_MIN, 1, e);
    expect_ev(K_HOUR, 1, e);
    btnMin  = 1'b1;
    btnHour = 1'b1;
    step(27);
    check("repeat_min_before_reset", int'(minUP), 1);
    check("repeat_hour_before_reset", int'(hourUP), 1);
    #2;
    CLR_n = 1'b0;
    #1;
    check("async_reset_mode", int'(Mode), 0);
    check("async_reset_minUP", int'(minUP), 0);
    check("async_reset_hourUP", int'(hourUP), 0);
    check("async_reset_alarmAck", int'(alarmAck), 0);
    step(2);
    CLR_n = 1'b1;
    step(40);
    check("held_through_reset_mode", int'(Mode), 0);
    btnMin  = 1'b0;
    btnHour = 1'b0;
    step(12);

    check("scoreboard_drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
